alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Producer side of the ALU operand/control interface. Accepts an op request (ALUOp, funct,
//  operands), decodes it to ALU_control/bonus_control, drives the ALU, captures result and flags,
//  returns them on a valid/ready response port. Multiply (ALU_control 8) is a multi-cycle path.
// PARAMETERS
//  DATA_W   32  operand/result width
//  MUL_LAT  3   cycles operands held stable for multiply before capture (>=1)
// PORTS
//  clk_i         in   1       clock, all logic on rising edge
//  rst_i         in   1       synchronous, active-high reset
//  req_valid_i   in   1       request valid
//  req_ready_o   out  1       request accepted when valid&ready
//  req_aluop_i   in   3       000 add, 001 sub, 010 R-type(funct), 011 addi, 100 slti, 101 compare
//  req_funct_i   in   6       funct field (R-type); [2:0] = bonus code for ALUOp 101
//  req_src1_i    in   DATA_W  operand 1
//  req_src2_i    in   DATA_W  operand 2
//  alu_src1_o    out  DATA_W  to ALU src1
//  alu_src2_o    out  DATA_W  to ALU src2
//  alu_ctrl_o    out  4       to ALU ALU_control
//  alu_bonus_o   out  3       to ALU bonus_control
//  alu_result_i  in   DATA_W  from ALU result
//  alu_zero_i    in   1       from ALU zero
//  alu_cout_i    in   1       from ALU cout
//  alu_ovf_i     in   1       from ALU overflow
//  rsp_valid_o   out  1       response valid, held until rsp_ready_i
//  rsp_ready_i   in   1       response consumed when valid&ready
//  rsp_result_o  out  DATA_W  captured result
//  rsp_zero_o / rsp_cout_o / rsp_ovf_o  out 1 each  captured flags
//  rsp_illegal_o out  1       request did not decode
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready_o=1; mul counter 0. Reset mid-op drops op, no rsp.
//  Decode: ALUOp 000/011 -> ctrl 2; 001 -> 6; 100 -> 7/bonus 000; 101 -> 7/bonus=funct[2:0]
//   (101,111 illegal); 010 by funct: 0x20->2, 0x22->6, 0x24->0, 0x25->1, 0x27->12, 0x2A->7/000,
//   0x18->8; other funct or ALUOp 11x illegal. bonus 000 when ctrl!=7.
//  FSM IDLE -> DRIVE | MULW | RESP; DRIVE -> RESP; MULW -> RESP; RESP -> IDLE.
//  IDLE: req_ready_o=1; on accept register operands, ctrl, bonus into alu_*_o (cycle N).
//   Legal non-mul -> DRIVE; mul -> MULW with count=MUL_LAT-1; illegal -> RESP with result 0,
//   flags 0, illegal 1 (rsp_valid_o at N+1, ALU outputs not updated).
//  DRIVE: alu_*_o stable in N+1; capture alu_result/flags at end of N+1; rsp_valid_o at N+2.
//  MULW: alu_*_o held; capture when count==0, else decrement; rsp_valid_o at N+1+MUL_LAT.
//  RESP: rsp_* stable while rsp_valid_o & !rsp_ready_i; on handshake -> IDLE, rsp_valid_o=0 next
//   cycle. req_ready_o=0 in all states but IDLE (one op in flight; no same-cycle req accept).
//  alu_*_o retain last value in IDLE (no glitch to ALU between ops).
//  Flags captured verbatim from ALU; block never recomputes zero/cout/overflow.
// STRUCTURE
//  alu_defs_pkg: ALU_control codes (AND 0, OR 1, ADD 2, SUB 6, CMP 7, MUL 8, NAND 12),
//   bonus codes (LT 000, GT 001, LE 010, GE 011, NE 100, EQ 110), ALUOp encodings, funct consts,
//   FSM state enum.
//  Sub-module alu_op_decoder: combinational {aluop,funct} -> {ctrl,bonus,is_mul,illegal}.
//  Top: FSM, operand/control regs, mul counter, response regs.
// TESTING
//  add: aluop 010 funct 0x20, src 5,7, rsp_ready=1 -> alu_ctrl 2, rsp_result 12, zero 0, valid at N+2.
//  mul: aluop 010 funct 0x18, src 6,-3, MUL_LAT=3 -> ctrl 8 held 3 cyc, result 0xFFFFFFEE at N+4.
//  compare: aluop 101 funct[2:0]=011, src -1,-1 -> ctrl 7 bonus 011, result 1; funct[2:0]=101 -> illegal=1, valid at N+1.
//  backpressure: rsp_ready=0 for 5 cyc after sub 3-3 -> rsp held result 0 zero 1, req_ready 0 throughout.
//  reset: assert rst_i during MULW -> next cycle IDLE, rsp_valid 0, req_ready 1, no stale rsp later.
//  back-to-back: two adds with valid held -> second accepted only cycle after first rsp handshake.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Purpose: shared ALU control/bonus codes, ALUOp and funct encodings, issue FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_defs_pkg;

   // ALU_control codes understood by the ALU
   localparam logic [3:0] CTRL_AND  = 4'd0;
   localparam logic [3:0] CTRL_OR   = 4'd1;
   localparam logic [3:0] CTRL_ADD  = 4'd2;
   localparam logic [3:0] CTRL_SUB  = 4'd6;
   localparam logic [3:0] CTRL_CMP  = 4'd7;
   localparam logic [3:0] CTRL_MUL  = 4'd8;
   localparam logic [3:0] CTRL_NAND = 4'd12;

   // bonus_control codes, meaningful only with CTRL_CMP
   localparam logic [2:0] BONUS_LT = 3'b000;
   localparam logic [2:0] BONUS_GT = 3'b001;
   localparam logic [2:0] BONUS_LE = 3'b010;
   localparam logic [2:0] BONUS_GE = 3'b011;
   localparam logic [2:0] BONUS_NE = 3'b100;
   localparam logic [2:0] BONUS_EQ = 3'b110;

   // ALUOp encodings from the main decoder
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_ADDI  = 3'b011;
   localparam logic [2:0] ALUOP_SLTI  = 3'b100;
   localparam logic [2:0] ALUOP_CMP   = 3'b101;

   // R-type funct values
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NAND = 6'h27;
   localparam logic [5:0] FUNCT_SLT  = 6'h2A;
   localparam logic [5:0] FUNCT_MUL  = 6'h18;

   // issue FSM states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_DRIVE = 2'd1;
   localparam state_t ST_MULW  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

   // decoder result bundle
   typedef struct packed {
      logic [3:0] ctrl;
      logic [2:0] bonus;
      logic       is_mul;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Purpose: map {ALUOp, funct} onto ALU_control / bonus_control, flag multiply and illegal ops.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
module alu_op_decoder
   import alu_defs_pkg::*;
(
   input  logic [2:0] aluop,
   input  logic [5:0] funct,
   output dec_t       dec
);

   // decode table; bonus stays 000 for every non-compare control
   always_comb begin
      dec = '{ctrl: CTRL_AND, bonus: BONUS_LT, is_mul: 1'b0, illegal: 1'b0};
      case (aluop)
         ALUOP_ADD, ALUOP_ADDI: dec.ctrl = CTRL_ADD;
         ALUOP_SUB:             dec.ctrl = CTRL_SUB;
         ALUOP_SLTI:            dec.ctrl = CTRL_CMP;
         ALUOP_CMP: begin
            dec.ctrl = CTRL_CMP;
            if (funct[2:0] == 3'b101 || funct[2:0] == 3'b111) begin
               dec.illegal = 1'b1;
            end else begin
               dec.bonus = funct[2:0];
            end
         end
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD:  dec.ctrl = CTRL_ADD;
               FUNCT_SUB:  dec.ctrl = CTRL_SUB;
               FUNCT_AND:  dec.ctrl = CTRL_AND;
               FUNCT_OR:   dec.ctrl = CTRL_OR;
               FUNCT_NAND: dec.ctrl = CTRL_NAND;
               FUNCT_SLT:  dec.ctrl = CTRL_CMP;
               FUNCT_MUL: begin
                  dec.ctrl   = CTRL_MUL;
                  dec.is_mul = 1'b1;
               end
               default:    dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
      // illegal ops never reach the ALU; keep the unused fields quiet
      if (dec.illegal) begin
         dec.ctrl   = CTRL_AND;
         dec.bonus  = BONUS_LT;
         dec.is_mul = 1'b0;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: accept one ALU op request, drive the ALU, capture result/flags, return on rsp port.
// Latency: rsp_valid 2 cycles after accept (multiply 1+MUL_LAT, illegal 1).
// Backpressure: one op in flight; req_ready low from accept until the response handshakes.
module alu_issue_ctrl
   import alu_defs_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_aluop_i,
   input  logic [5:0]        req_funct_i,
   input  logic [DATA_W-1:0] req_src1_i,
   input  logic [DATA_W-1:0] req_src2_i,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   output logic [3:0]        alu_ctrl_o,
   output logic [2:0]        alu_bonus_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   input  logic              alu_cout_i,
   input  logic              alu_ovf_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic              rsp_zero_o,
   output logic              rsp_cout_o,
   output logic              rsp_ovf_o,
   output logic              rsp_illegal_o
);

   localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

   state_t           state;
   logic [CNT_W-1:0] mul_cnt;
   dec_t             dec;

   alu_op_decoder u_dec (
      .aluop (req_aluop_i),
      .funct (req_funct_i),
      .dec   (dec)
   );

   // ready only while idle; response valid exactly while waiting in RESP
   always_comb begin
      req_ready_o = (state == ST_IDLE);
      rsp_valid_o = (state == ST_RESP);
   end

   // issue FSM with operand/control, multiply counter and response registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         mul_cnt       <= '0;
         alu_src1_o    <= '0;
         alu_src2_o    <= '0;
         alu_ctrl_o    <= '0;
         alu_bonus_o   <= '0;
         rsp_result_o  <= '0;
         rsp_zero_o    <= 1'b0;
         rsp_cout_o    <= 1'b0;
         rsp_ovf_o     <= 1'b0;
         rsp_illegal_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  if (dec.illegal) begin
                     // ALU is left untouched; respond directly with a zeroed result
                     rsp_result_o  <= '0;
                     rsp_zero_o    <= 1'b0;
                     rsp_cout_o    <= 1'b0;
                     rsp_ovf_o     <= 1'b0;
                     rsp_illegal_o <= 1'b1;
                     state         <= ST_RESP;
                  end else begin
                     alu_src1_o    <= req_src1_i;
                     alu_src2_o    <= req_src2_i;
                     alu_ctrl_o    <= dec.ctrl;
                     alu_bonus_o   <= dec.bonus;
                     rsp_illegal_o <= 1'b0;
                     if (dec.is_mul) begin
                        mul_cnt <= CNT_LOAD;
                        state   <= ST_MULW;
                     end else begin
                        state   <= ST_DRIVE;
                     end
                  end
               end
            end
            ST_DRIVE: begin
               rsp_result_o <= alu_result_i;
               rsp_zero_o   <= alu_zero_i;
               rsp_cout_o   <= alu_cout_i;
               rsp_ovf_o    <= alu_ovf_i;
               state        <= ST_RESP;
            end
            ST_MULW: begin
               // operands held stable until the multiplier path has settled
               if (mul_cnt == '0) begin
                  rsp_result_o <= alu_result_i;
                  rsp_zero_o   <= alu_zero_i;
                  rsp_cout_o   <= alu_cout_i;
                  rsp_ovf_o    <= alu_ovf_i;
                  state        <= ST_RESP;
               end else begin
                  mul_cnt <= mul_cnt - CNT_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Purpose: directed vector table plus multi-cycle sequences around alu_issue_ctrl with an ALU model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_alu_issue_ctrl;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [2:0]        req_aluop = '0;
   logic [5:0]        req_funct = '0;
   logic [DATA_W-1:0] req_src1 = '0;
   logic [DATA_W-1:0] req_src2 = '0;
   logic [DATA_W-1:0] alu_src1, alu_src2, alu_result;
   logic [3:0]        alu_ctrl;
   logic [2:0]        alu_bonus;
   logic              alu_zero, alu_cout, alu_ovf;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero, rsp_cout, rsp_ovf, rsp_illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_aluop_i(req_aluop), .req_funct_i(req_funct),
      .req_src1_i(req_src1), .req_src2_i(req_src2),
      .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
      .alu_ctrl_o(alu_ctrl), .alu_bonus_o(alu_bonus),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero),
      .alu_cout_i(alu_cout), .alu_ovf_i(alu_ovf),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
      .rsp_cout_o(rsp_cout), .rsp_ovf_o(rsp_ovf),
      .rsp_illegal_o(rsp_illegal)
   );

   // ---------------- ALU model; multiply only valid after MUL_LAT stable cycles
   int          stab = 0;
   logic [67:0] prev_key;
   always @(negedge clk) begin
      if ({alu_src1, alu_src2, alu_ctrl} === prev_key) stab <= stab + 1;
      else stab <= 1;
      prev_key <= {alu_src1, alu_src2, alu_ctrl};
   end

   logic [32:0] sum;
   always_comb begin
      sum = '0;
      alu_result = '0;
      alu_cout = 1'b0;
      alu_ovf = 1'b0;
      case (alu_ctrl)
         4'd0:  alu_result = alu_src1 & alu_src2;
         4'd1:  alu_result = alu_src1 | alu_src2;
         4'd12: alu_result = ~(alu_src1 & alu_src2);
         4'd2: begin
            sum = {1'b0, alu_src1} + {1'b0, alu_src2};
            alu_result = sum[31:0];
            alu_cout = sum[32];
            alu_ovf = (alu_src1[31] == alu_src2[31]) && (alu_result[31] != alu_src1[31]);
         end
         4'd6: begin
            sum = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 33'd1;
            alu_result = sum[31:0];
            alu_cout = sum[32];
            alu_ovf = (alu_src1[31] != alu_src2[31]) && (alu_result[31] != alu_src1[31]);
         end
         4'd7: begin
            case (alu_bonus)
               3'b000: alu_result = {31'd0, $signed(alu_src1) <  $signed(alu_src2)};
               3'b001: alu_result = {31'd0, $signed(alu_src1) >  $signed(alu_src2)};
               3'b010: alu_result = {31'd0, $signed(alu_src1) <= $signed(alu_src2)};
               3'b011: alu_result = {31'd0, $signed(alu_src1) >= $signed(alu_src2)};
               3'b100: alu_result = {31'd0, alu_src1 != alu_src2};
               3'b110: alu_result = {31'd0, alu_src1 == alu_src2};
               default: alu_result = 32'hBADC0DE0;
            endcase
         end
         4'd8: alu_result = (stab >= MUL_LAT) ? alu_src1 * alu_src2 : 32'hDEADBEEF;
         default: alu_result = 32'hBADC0DE1;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   // ---------------- checking helpers
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  aluop;
      logic [5:0]  funct;
      logic [31:0] s1, s2;
      logic [3:0]  ctrl;
      logic [2:0]  bonus;
      logic [31:0] res;
      logic        z, c, o, ill;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   // last operands/control that legally reached the ALU
   logic [31:0] last_s1 = '0, last_s2 = '0;
   logic [3:0]  last_ctrl = '0;
   logic [2:0]  last_bonus = '0;

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      bit busy_ok, held_ok;
      logic [73:0] snap;
      string tag;
      tag = $sformatf("v%0d", idx);
      @(negedge clk);
      req_aluop = v.aluop; req_funct = v.funct;
      req_src1 = v.s1; req_src2 = v.s2; req_valid = 1'b1;
      for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
      check({tag, "_accept"}, req_ready, 1'b1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; busy_ok = 1; held_ok = 1; snap = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (req_ready) busy_ok = 0;
         if (k == 1) snap = {alu_src1, alu_src2, alu_ctrl, alu_bonus, 3'b000};
         else if (!rsp_valid && snap != {alu_src1, alu_src2, alu_ctrl, alu_bonus, 3'b000}) held_ok = 0;
         if (rsp_valid) begin lat = k; break; end
      end
      check({tag, "_latency"}, lat, v.lat);
      check({tag, "_result"}, rsp_result, v.res);
      check({tag, "_flags_zco"}, {rsp_zero, rsp_cout, rsp_ovf}, {v.z, v.c, v.o});
      check({tag, "_illegal"}, rsp_illegal, v.ill);
      check({tag, "_busy_ready"}, busy_ok, 1'b1);
      check({tag, "_alu_held"}, held_ok, 1'b1);
      if (v.ill) begin
         check({tag, "_alu_untouched"}, snap, {last_s1, last_s2, last_ctrl, last_bonus, 3'b000});
      end else begin
         check({tag, "_alu_drive"}, snap, {v.s1, v.s2, v.ctrl, v.bonus, 3'b000});
         last_s1 = v.s1; last_s2 = v.s2; last_ctrl = v.ctrl; last_bonus = v.bonus;
      end
      @(negedge clk);
      check({tag, "_after_hs"}, {rsp_valid, req_ready}, 2'b01);
   endtask

   // ---------------- stimulus
   int n;
   logic [31:0] r_a;
   initial begin
      //          aluop   funct  s1            s2            ctrl  bon  res           z c o ill lat
      vecs[0]  = '{3'b010, 6'h20, 32'd5,        32'd7,        4'd2, 3'd0, 32'd12,       0,0,0,0, 2};
      vecs[1]  = '{3'b010, 6'h18, 32'd6,        32'hFFFFFFFD, 4'd8, 3'd0, 32'hFFFFFFEE, 0,0,0,0, 4};
      vecs[2]  = '{3'b101, 6'h03, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 3'd3, 32'd1,        0,0,0,0, 2};
      vecs[3]  = '{3'b101, 6'h05, 32'd1,        32'd2,        4'd0, 3'd0, 32'd0,        0,0,0,1, 1};
      vecs[4]  = '{3'b001, 6'h00, 32'd3,        32'd3,        4'd6, 3'd0, 32'd0,        1,1,0,0, 2};
      vecs[5]  = '{3'b010, 6'h24, 32'h0000F0F0, 32'h0000FF00, 4'd0, 3'd0, 32'h0000F000, 0,0,0,0, 2};
      vecs[6]  = '{3'b010, 6'h25, 32'h0000F0F0, 32'h00000F0F, 4'd1, 3'd0, 32'h0000FFFF, 0,0,0,0, 2};
      vecs[7]  = '{3'b010, 6'h27, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12,3'd0, 32'd0,        1,0,0,0, 2};
      vecs[8]  = '{3'b010, 6'h2A, 32'hFFFFFFFB, 32'd3,        4'd7, 3'd0, 32'd1,        0,0,0,0, 2};
      vecs[9]  = '{3'b011, 6'h3F, 32'h7FFFFFFF, 32'd1,        4'd2, 3'd0, 32'h80000000, 0,0,1,0, 2};
      vecs[10] = '{3'b100, 6'h07, 32'd10,       32'd2,        4'd7, 3'd0, 32'd0,        1,0,0,0, 2};
      vecs[11] = '{3'b110, 6'h20, 32'd9,        32'd9,        4'd0, 3'd0, 32'd0,        0,0,0,1, 1};
      vecs[12] = '{3'b010, 6'h21, 32'd9,        32'd9,        4'd0, 3'd0, 32'd0,        0,0,0,1, 1};
      vecs[13] = '{3'b000, 6'h00, 32'hFFFFFFFF, 32'd1,        4'd2, 3'd0, 32'd0,        1,1,0,0, 2};
      vecs[14] = '{3'b101, 6'h04, 32'd4,        32'd5,        4'd7, 3'd4, 32'd1,        0,0,0,0, 2};
      vecs[15] = '{3'b101, 6'h07, 32'd4,        32'd4,        4'd0, 3'd0, 32'd0,        0,0,0,1, 1};
      vecs[16] = '{3'b101, 6'h06, 32'd9,        32'd9,        4'd7, 3'd6, 32'd1,        0,0,0,0, 2};
      vecs[17] = '{3'b101, 6'h01, 32'd2,        32'hFFFFFFFF, 4'd7, 3'd1, 32'd1,        0,0,0,0, 2};
      vecs[18] = '{3'b101, 6'h02, 32'd7,        32'd3,        4'd7, 3'd2, 32'd0,        1,0,0,0, 2};
      vecs[19] = '{3'b010, 6'h22, 32'd2,        32'd5,        4'd6, 3'd0, 32'hFFFFFFFD, 0,0,0,0, 2};

      // reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_ready_valid", {req_ready, rsp_valid}, 2'b10);
      check("rst_rsp", {rsp_result, rsp_zero, rsp_cout, rsp_ovf, rsp_illegal}, 36'd0);
      check("rst_alu", {alu_src1, alu_src2, alu_ctrl, alu_bonus}, 71'd0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // backpressure: sub 3-3 with rsp_ready low, a second request waiting meanwhile
      rsp_ready = 1'b0;
      @(negedge clk);
      req_aluop = 3'b001; req_funct = 6'h00; req_src1 = 32'd3; req_src2 = 32'd3; req_valid = 1'b1;
      @(posedge clk);
      #1 req_src1 = 32'd100; req_src2 = 32'd1;
      n = 0;
      for (int k = 0; k < 10 && !rsp_valid; k++) begin @(negedge clk); n++; end
      check("bp_latency", n, 2);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_hold%0d", k), {rsp_valid, req_ready, rsp_result, rsp_zero},
               {1'b1, 1'b0, 32'd0, 1'b1});
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {rsp_valid, req_ready}, 2'b01);
      // the waiting request is now accepted
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("bp_second_rsp", {rsp_valid, rsp_result}, {1'b1, 32'd99});
      @(negedge clk);

      // reset during MULW drops the op
      req_aluop = 3'b010; req_funct = 6'h18; req_src1 = 32'd4; req_src2 = 32'd5; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("mulw_ctrl", alu_ctrl, 4'd8);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_mid_state", {rsp_valid, req_ready}, 2'b01);
      check("rst_mid_alu", {alu_src1, alu_ctrl}, 36'd0);
      n = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (rsp_valid) n++; end
      check("rst_no_stale_rsp", n, 0);
      last_s1 = '0; last_s2 = '0; last_ctrl = '0; last_bonus = '0;

      // back-to-back adds with valid held
      @(negedge clk);
      req_aluop = 3'b000; req_src1 = 32'd10; req_src2 = 32'd20; req_valid = 1'b1;
      @(posedge clk);
      #1 req_src1 = 32'd1; req_src2 = 32'd2;
      n = 0; r_a = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (rsp_valid) r_a = rsp_result;
         if (req_ready) begin n = k; break; end
      end
      check("b2b_first_result", r_a, 32'd30);
      check("b2b_second_accept", {n, rsp_valid}, {32'd3, 1'b0});
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("b2b_second_rsp", {rsp_valid, rsp_result}, {1'b1, 32'd3});
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
